cpu_mem_responder: RTL and testbench

//  Memory-side responder for cpu_core: serves the instruction fetch port and the data load/store port.

---
 rtl/cpu_mem_pkg.sv | 18 +
 rtl/mem_2r1w_array.sv | 75 +++++++
 rtl/cpu_mem_responder.sv | 134 +++++++++++++
 tb/tb_cpu_mem_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and helpers for the cpu_core memory responder.
// The optional MEM_PARITY_EN build uses parity_even() to protect each stored word.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam int unsigned PAR_MAX_W = 64;

    // Even-parity bit: XOR of all bits, so data plus parity XORs to zero.
    function automatic logic parity_even(input logic [PAR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/mem_2r1w_array.sv
// DEPTH-word storage with one write port and two registered read ports (old data on collision).
// MEM_PARITY_EN adds a stored even-parity bit per word and combinational mismatch flags.
module mem_2r1w_array
    import cpu_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] raddr0,
    input  logic [DEPTH_LOG2-1:0] raddr1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  perr0_c,
    output logic                  perr1_c
);

`ifdef MEM_PARITY_EN
    localparam int unsigned PW = 1;
`else
    localparam int unsigned PW = 0;
`endif
    localparam int unsigned MW    = DATA_WIDTH + PW;
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic [MW-1:0]         mem_q [DEPTH];
    logic [MW-1:0]         wword_c;
    logic [DATA_WIDTH-1:0] rdata0_d, rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_d, rdata1_q;

`ifdef MEM_PARITY_EN
    assign wword_c = {parity_even(PAR_MAX_W'(wdata)), wdata};
    assign perr0_c = rd_en && (^mem_q[raddr0]);
    assign perr1_c = rd_en && (^mem_q[raddr1]);
`else
    assign wword_c = wdata;
    assign perr0_c = 1'b0;
    assign perr1_c = 1'b0;
`endif

    // Storage carries no reset; the owner clears it explicitly after every reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wword_c;
        end
    end

    always_comb begin
        rdata0_d = '0;
        rdata1_d = '0;
        if (rd_en) begin
            rdata0_d = mem_q[raddr0][DATA_WIDTH-1:0];
            rdata1_d = mem_q[raddr1][DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory responder for cpu_core: clears the array, accepts a boot image, then serves fetch/load/store.
// Optional MEM_PARITY_EN build adds per-word parity and a sticky parity_err flag.
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_data,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_wen,
    output logic [DATA_WIDTH-1:0] dmem_rdata,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_err,
    output logic                  cpu_enable,
    output logic                  parity_err
);

    localparam int unsigned           DEPTH   = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] CNT_MAX = DEPTH_LOG2'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
    logic                  load_err_q, load_err_d;
    logic                  load_ready_q, load_ready_d;
    logic                  cpu_enable_q, cpu_enable_d;
    logic                  parity_err_q, parity_err_d;

    logic                  we_c;
    logic [DEPTH_LOG2-1:0] waddr_c;
    logic [DATA_WIDTH-1:0] wdata_c;
    logic                  rd_en_c;
    logic                  perr0_c, perr1_c;
    logic                  unused_addr_bits;

    // Upper address bits are deliberately dropped: accesses wrap modulo DEPTH.
    assign unused_addr_bits = ^{imem_addr[ADDR_WIDTH-1:DEPTH_LOG2], dmem_addr[ADDR_WIDTH-1:DEPTH_LOG2]};

    assign rd_en_c = (state_q == ST_RUN);

    // Next state, counter, flags and the clear/load/store write mux.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        load_err_d   = load_err_q;
        we_c         = 1'b0;
        waddr_c      = cnt_q;
        wdata_c      = '0;
        case (state_q)
            ST_CLEAR: begin
                we_c  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_MAX) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_valid && load_ready_q) begin
                    we_c    = 1'b1;
                    wdata_c = load_data;
                    cnt_d   = cnt_q + 1'b1;
                    if (load_last) begin
                        state_d = ST_RUN;
                    end else if (cnt_q == CNT_MAX) begin
                        load_err_d = 1'b1;
                        state_d    = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                we_c    = dmem_wen;
                waddr_c = dmem_addr[DEPTH_LOG2-1:0];
                wdata_c = dmem_wdata;
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
        load_ready_d = (state_d == ST_LOAD);
        cpu_enable_d = (state_d == ST_RUN);
        parity_err_d = parity_err_q | perr0_c | perr1_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            cnt_q        <= '0;
            load_err_q   <= 1'b0;
            load_ready_q <= 1'b0;
            cpu_enable_q <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            load_err_q   <= load_err_d;
            load_ready_q <= load_ready_d;
            cpu_enable_q <= cpu_enable_d;
            parity_err_q <= parity_err_d;
        end
    end

    mem_2r1w_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we_c),
        .waddr  (waddr_c),
        .wdata  (wdata_c),
        .rd_en  (rd_en_c),
        .raddr0 (imem_addr[DEPTH_LOG2-1:0]),
        .raddr1 (dmem_addr[DEPTH_LOG2-1:0]),
        .rdata0 (imem_data),
        .rdata1 (dmem_rdata),
        .perr0_c(perr0_c),
        .perr1_c(perr1_c)
    );

    assign load_ready = load_ready_q;
    assign load_err   = load_err_q;
    assign cpu_enable = cpu_enable_q;
    assign parity_err = parity_err_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder (DEPTH_LOG2=4): boot clear, image load, RUN access, overrun, reset.
// Build with MEM_PARITY_EN defined to also exercise the parity fault path.
module tb_cpu_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] imem_addr, dmem_addr;
    logic [31:0] imem_data, dmem_rdata, dmem_wdata, load_data;
    logic        dmem_wen, load_valid, load_ready, load_last, load_err, cpu_enable, parity_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] ia;
        logic [15:0] da;
        logic        wen;
        logic [31:0] wd;
        logic [31:0] ei;
        logic [31:0] ed;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] ei;
        logic [31:0] ed;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];

    cpu_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH_LOG2(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_wen  (dmem_wen),
        .dmem_rdata(dmem_rdata),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
        .load_last (load_last),
        .load_err  (load_err),
        .cpu_enable(cpu_enable),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_addr  = '0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_wen   = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!load_ready && n < 40) begin
            step();
            n++;
        end
        check("wait_load_ready", 32'(load_ready), 32'd1);
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_cpu_enable", 32'(cpu_enable), 32'd0);
        check("reset_load_ready", 32'(load_ready), 32'd0);
        check("reset_load_err",   32'(load_err),   32'd0);
        check("reset_parity_err", 32'(parity_err), 32'd0);
        check("reset_imem_data",  imem_data,       32'd0);
        check("reset_dmem_rdata", dmem_rdata,      32'd0);
        step();
        step();
        rst_n = 1'b1;

        // Clear phase: ready stays low for 15 edges, rises on the 16th.
        for (int i = 1; i <= 15; i++) begin
            step();
            check("clear_ready_low", 32'(load_ready), 32'd0);
            check("clear_enable_low", 32'(cpu_enable), 32'd0);
        end
        step();
        check("clear_ready_high", 32'(load_ready), 32'd1);

        // Image A,B,C with two idle cycles between words.
        send_word(32'hA, 1'b0);
        step();
        step();
        send_word(32'hB, 1'b0);
        check("load_enable_still_low", 32'(cpu_enable), 32'd0);
        step();
        step();
        send_word(32'hC, 1'b1);
        check("load_done_enable", 32'(cpu_enable), 32'd1);
        check("load_done_ready",  32'(load_ready), 32'd0);
        imem_addr = 16'd1;
        dmem_addr = 16'd3;
        step();
        check("run_fetch_word1", imem_data,  32'hB);
        check("run_load_word3",  dmem_rdata, 32'h0);

        // Store to 0x15 wraps to word 5; fetch of word 5 in the same cycle sees old data.
        dmem_wen   = 1'b1;
        dmem_addr  = 16'h0015;
        dmem_wdata = 32'h1234;
        imem_addr  = 16'd5;
        step();
        check("rdw_old_data", imem_data, 32'h0);
        dmem_wen  = 1'b0;
        dmem_addr = 16'd5;
        step();
        check("wrap_store_word5", dmem_rdata, 32'h1234);

        // Memory now: 0=A 1=B 2=C 5=1234, rest 0.
        vecs[0] = '{ia: 16'h0000, da: 16'h0002, wen: 1'b0, wd: 32'h0,        ei: 32'hA,        ed: 32'hC};
        vecs[1] = '{ia: 16'h0011, da: 16'hFFF7, wen: 1'b1, wd: 32'hDEAD,     ei: 32'hB,        ed: 32'h0};
        vecs[2] = '{ia: 16'h0007, da: 16'h0007, wen: 1'b0, wd: 32'h0,        ei: 32'hDEAD,     ed: 32'hDEAD};
        vecs[3] = '{ia: 16'h000F, da: 16'h0010, wen: 1'b1, wd: 32'h55,       ei: 32'h0,        ed: 32'hA};
        vecs[4] = '{ia: 16'h0000, da: 16'h000F, wen: 1'b1, wd: 32'hFFFFFFFF, ei: 32'h55,       ed: 32'h0};
        vecs[5] = '{ia: 16'h800F, da: 16'h0005, wen: 1'b0, wd: 32'h0,        ei: 32'hFFFFFFFF, ed: 32'h1234};
        for (int i = 0; i < 6; i++) begin
            exp_t e;
            imem_addr  = vecs[i].ia;
            dmem_addr  = vecs[i].da;
            dmem_wen   = vecs[i].wen;
            dmem_wdata = vecs[i].wd;
            sb.push_back('{idx: i, ei: vecs[i].ei, ed: vecs[i].ed});
            step();
            e = sb.pop_front();
            check($sformatf("vec%0d_imem", e.idx), imem_data,  e.ei);
            check($sformatf("vec%0d_dmem", e.idx), dmem_rdata, e.ed);
        end
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        idle_inputs();

        // Overrun: 16 words without last.
        apply_reset();
        wait_ready();
        for (int i = 0; i < 16; i++) begin
            send_word(32'h100 + 32'(i), 1'b0);
            if (i == 14) begin
                check("overrun_err_before", 32'(load_err),   32'd0);
                check("overrun_en_before",  32'(cpu_enable), 32'd0);
            end
        end
        check("overrun_load_err", 32'(load_err),   32'd1);
        check("overrun_enable",   32'(cpu_enable), 32'd1);
        check("overrun_ready",    32'(load_ready), 32'd0);
        imem_addr = 16'd0;
        send_word(32'hBAD, 1'b0);
        step();
        check("overrun_word0_kept", imem_data, 32'h100);
        check("overrun_err_sticky", 32'(load_err), 32'd1);
        idle_inputs();

        // Reset mid-load after two words, then a one-word image.
        apply_reset();
        wait_ready();
        send_word(32'h11, 1'b0);
        send_word(32'h22, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_ready",      32'(load_ready), 32'd0);
        check("midreset_enable",     32'(cpu_enable), 32'd0);
        check("midreset_load_err",   32'(load_err),   32'd0);
        check("midreset_imem",       imem_data,       32'd0);
        check("midreset_dmem",       dmem_rdata,      32'd0);
        step();
        rst_n = 1'b1;
        wait_ready();
        send_word(32'h7, 1'b1);
        check("reboot_enable", 32'(cpu_enable), 32'd1);
        imem_addr = 16'd0;
        dmem_addr = 16'd1;
        step();
        check("reboot_word0", imem_data,  32'h7);
        check("reboot_word1", dmem_rdata, 32'h0);

`ifdef MEM_PARITY_EN
        dut.u_array.mem_q[2] <= dut.u_array.mem_q[2] ^ 33'h1;
        #1;
        imem_addr = 16'd2;
        step();
        check("parity_detect", 32'(parity_err), 32'd1);
        imem_addr = 16'd0;
        step();
        step();
        check("parity_sticky", 32'(parity_err), 32'd1);
`else
        imem_addr = 16'd2;
        step();
        step();
        check("parity_tied_low", 32'(parity_err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
